// File: rtl/seg_pkg.sv
// Shared types and helpers for the seven-segment display arbiter.
package seg_pkg;

    localparam int DISP_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } seg_state_t;

    // Width of an index able to address n requesters.
    function automatic int owner_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/seg_display_arbiter_rr_pick.sv
// Round-robin search: first set bit of (req & ~excl) starting at start_i, wrapping.
module rr_pick
    import seg_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   start_i,
    input  logic [NUM_REQ-1:0] excl_i,
    output logic               found_o,
    output logic [IDX_W-1:0]   idx_o
);

    logic [NUM_REQ-1:0] masked_s;

    // Walk the candidates in rotation order and keep the first hit.
    always_comb begin
        found_o  = 1'b0;
        idx_o    = {IDX_W{1'b0}};
        masked_s = req_i & ~excl_i;
        for (int i = 0; i < NUM_REQ; i++) begin
            int k;
            k = (int'(start_i) + i) % NUM_REQ;
            if (!found_o && masked_s[k]) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(k);
            end else begin
                found_o = found_o;
                idx_o   = idx_o;
            end
        end
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin owner selection for the shared 8-digit display with minimum dwell and debug lock.
module seg_display_arbiter
    import seg_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DWELL_CYCLES = 100_000_000
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [DISP_W*NUM_REQ-1:0]     req_data_i,
    input  logic                          lock_i,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic [owner_w(NUM_REQ)-1:0]   owner_o,
    output logic [DISP_W-1:0]             disp_data_o,
    output logic                          disp_blank_o,
    output logic                          dwell_done_o
);

    localparam int OWN_W = owner_w(NUM_REQ);
    localparam int CNT_W = $clog2(DWELL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL_CYCLES - 1);

    seg_state_t          state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [OWN_W-1:0]    owner_q, owner_d;
    logic [OWN_W-1:0]    last_q, last_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                done_q, done_d;
    logic [DISP_W-1:0]   data_q, data_d;
    logic                blank_q, blank_d;

    logic [OWN_W-1:0]    start_s;
    logic [NUM_REQ-1:0]  excl_s;
    logic                pick_found_s;
    logic [OWN_W-1:0]    pick_idx_s;
    logic                new_grant_s;

    // Search origin: one past the owner while owning (owner excluded), one past last grant when idle.
    always_comb begin
        if (state_q == OWN) begin
            start_s = owner_q + OWN_W'(1);
            excl_s  = grant_q;
        end else begin
            start_s = last_q + OWN_W'(1);
            excl_s  = {NUM_REQ{1'b0}};
        end
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (OWN_W)
    ) u_pick (
        .req_i   (req_i),
        .start_i (start_s),
        .excl_i  (excl_s),
        .found_o (pick_found_s),
        .idx_o   (pick_idx_s)
    );

    // Next-state, grant, dwell and data-path decisions.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        done_d      = done_q;
        data_d      = data_q;
        new_grant_s = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_found_s) begin
                    new_grant_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN: begin
                if (!req_i[owner_q]) begin
                    // Release wins over dwell and lock.
                    if (pick_found_s) begin
                        new_grant_s = 1'b1;
                    end else begin
                        state_d = IDLE;
                        grant_d = {NUM_REQ{1'b0}};
                        cnt_d   = {CNT_W{1'b0}};
                        done_d  = 1'b0;
                    end
                end else if (done_q && !lock_i && pick_found_s) begin
                    new_grant_s = 1'b1;
                end else begin
                    cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                    done_d = (cnt_d == CNT_MAX);
                    data_d = req_data_i[int'(owner_q)*DISP_W +: DISP_W];
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (new_grant_s) begin
            state_d = OWN;
            grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
            owner_d = pick_idx_s;
            last_d  = pick_idx_s;
            cnt_d   = {CNT_W{1'b0}};
            done_d  = 1'b0;
            data_d  = req_data_i[int'(pick_idx_s)*DISP_W +: DISP_W];
        end else begin
            state_d = state_d;
        end

        blank_d = (state_d == IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= {NUM_REQ{1'b0}};
            owner_q <= {OWN_W{1'b0}};
            last_q  <= OWN_W'(NUM_REQ - 1);
            cnt_q   <= {CNT_W{1'b0}};
            done_q  <= 1'b0;
            data_q  <= {DISP_W{1'b0}};
            blank_q <= 1'b1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            data_q  <= data_d;
            blank_q <= blank_d;
        end
    end

    assign grant_o      = grant_q;
    assign owner_o      = owner_q;
    assign disp_data_o  = data_q;
    assign disp_blank_o = blank_q;
    assign dwell_done_o = done_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with NUM_REQ=4, DWELL_CYCLES=4.
module tb_seg_display_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   req;
    logic [127:0] req_data;
    logic         lock;
    logic [3:0]   grant;
    logic [1:0]   owner;
    logic [31:0]  disp_data;
    logic         disp_blank;
    logic         dwell_done;

    int total = 0;
    int bad   = 0;

    seg_display_arbiter #(
        .NUM_REQ      (4),
        .DWELL_CYCLES (4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .req_data_i   (req_data),
        .lock_i       (lock),
        .grant_o      (grant),
        .owner_o      (owner),
        .disp_data_o  (disp_data),
        .disp_blank_o (disp_blank),
        .dwell_done_o (dwell_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word(input int k);
        return 32'hA5A5_0000 + 32'(k) * 32'h0000_1111;
    endfunction

    initial begin
        logic [3:0] exp_g;
        int         g;

        rst  = 1'b1;
        lock = 1'b0;
        req  = 4'b1111;
        for (int k = 0; k < 4; k++) req_data[k*32 +: 32] = word(k);

        // Reset held for two cycles
        for (int c = 0; c < 2; c++) begin
            step();
            chk("rst_grant", {28'd0, grant}, 32'h0);
            chk("rst_owner", {30'd0, owner}, 32'h0);
            chk("rst_blank", {31'd0, disp_blank}, 32'h1);
            chk("rst_data", disp_data, 32'h0);
            chk("rst_done", {31'd0, dwell_done}, 32'h0);
        end
        rst = 1'b0;
        step();
        chk("first_grant", {28'd0, grant}, 32'h1);
        chk("first_data", disp_data, word(0));

        // Rotation with all four requesting: 0,1,2,3,0 each for 4 cycles
        for (int n = 0; n < 5; n++) begin
            g = n % 4;
            exp_g = 4'b0001 << g;
            for (int c = 0; c < 4; c++) begin
                chk("rot_grant", {28'd0, grant}, {28'd0, exp_g});
                chk("rot_owner", {30'd0, owner}, 32'(g));
                chk("rot_done", {31'd0, dwell_done}, (c == 3) ? 32'h1 : 32'h0);
                chk("rot_blank", {31'd0, disp_blank}, 32'h0);
                chk("rot_data", disp_data, word(g));
                step();
            end
        end
        chk("rot_wrap_grant", {28'd0, grant}, 32'h2);

        // Owner 1 releases, only requester 0 left
        req = 4'b0001;
        step();
        chk("rel_to0_grant", {28'd0, grant}, 32'h1);
        req = 4'b0011;
        step();
        chk("early_pre_grant", {28'd0, grant}, 32'h1);
        // Drop req[0] in dwell cycle 1
        req = 4'b0010;
        step();
        chk("early_grant", {28'd0, grant}, 32'h2);
        chk("early_done0", {31'd0, dwell_done}, 32'h0);
        chk("early_data", disp_data, word(1));
        for (int c = 1; c < 6; c++) begin
            step();
            chk("early_hold_grant", {28'd0, grant}, 32'h2);
            chk("early_done", {31'd0, dwell_done}, (c >= 3) ? 32'h1 : 32'h0);
        end

        // Lock: owner 0 with requester 2 pending
        req = 4'b0001;
        step();
        chk("lock_pre_grant", {28'd0, grant}, 32'h1);
        req  = 4'b0101;
        lock = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("lock_grant", {28'd0, grant}, 32'h1);
            chk("lock_done", {31'd0, dwell_done}, (i >= 3) ? 32'h1 : 32'h0);
            if (i < 19) step();
        end
        lock = 1'b0;
        step();
        chk("unlock_grant", {28'd0, grant}, 32'h4);
        chk("unlock_owner", {30'd0, owner}, 32'h2);
        chk("unlock_done", {31'd0, dwell_done}, 32'h0);

        // Single requester 2 with live data
        req = 4'b0100;
        req_data[64 +: 32] = 32'h1234_5678;
        step();
        chk("live_data1", disp_data, 32'h1234_5678);
        req_data[64 +: 32] = 32'hDEAD_BEEF;
        #1;
        chk("live_lag", disp_data, 32'h1234_5678);
        step();
        chk("live_data2", disp_data, 32'hDEAD_BEEF);
        for (int c = 0; c < 6; c++) begin
            step();
            chk("live_grant", {28'd0, grant}, 32'h4);
            chk("live_blank", {31'd0, disp_blank}, 32'h0);
        end
        req = 4'b0000;
        for (int c = 0; c < 2; c++) begin
            step();
            chk("idle_blank", {31'd0, disp_blank}, 32'h1);
            chk("idle_grant", {28'd0, grant}, 32'h0);
            chk("idle_owner", {30'd0, owner}, 32'h2);
            chk("idle_data", disp_data, 32'hDEAD_BEEF);
            chk("idle_done", {31'd0, dwell_done}, 32'h0);
        end

        // Mid-operation reset with owner 3 at dwell count 2
        req = 4'b1000;
        step();
        chk("mid_grant3", {28'd0, grant}, 32'h8);
        chk("mid_data3", disp_data, word(3));
        step();
        step();
        chk("mid_before_rst", {28'd0, grant}, 32'h8);
        req = 4'b1111;
        rst = 1'b1;
        step();
        chk("mid_rst_grant", {28'd0, grant}, 32'h0);
        chk("mid_rst_owner", {30'd0, owner}, 32'h0);
        chk("mid_rst_blank", {31'd0, disp_blank}, 32'h1);
        chk("mid_rst_data", disp_data, 32'h0);
        chk("mid_rst_done", {31'd0, dwell_done}, 32'h0);
        rst = 1'b0;
        step();
        chk("post_rst_grant", {28'd0, grant}, 32'h1);
        chk("post_rst_data", disp_data, word(0));
        for (int c = 1; c < 5; c++) begin
            step();
            chk("post_rst_hold", {28'd0, grant}, (c < 4) ? 32'h1 : 32'h2);
            chk("post_rst_done", {31'd0, dwell_done}, (c == 3) ? 32'h1 : 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
